result_collector: RTL and testbench
===================================

Name: result_collector

Overview:
- Receives the indexed, scaled result stream from the scaler: one `(index, value)` pair per enabled cycle, indices cycling 0..CELL_AMOUNT-1.
- Reassembles each group of CELL_AMOUNT values into one packed output row.
- Buffers completed rows in a small row FIFO.
- Presents rows downstream over a valid/ready handshake; sits between the scaler and the output writer/host interface.

Parameters:
- DATA_WIDTH, 8, width of one scaled value and of the index field
- CELL_AMOUNT, 4, values per row (number of systolic cells)
- ROW_DEPTH, 2, row FIFO depth in rows; power of two, >= 2

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst_n  input  1  synchronous active-low reset
- input_index  input  DATA_WIDTH  slot index of the incoming value
- input_value  input  DATA_WIDTH  scaled value
- input_enable  input  1  input_index/input_value valid this cycle
- row_data  output  CELL_AMOUNT*DATA_WIDTH  packed head row; slot i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- row_valid  output  1  FIFO non-empty; row_data is meaningful
- row_ready  input  1  downstream accepts row_data this cycle
- row_count  output  clog2(ROW_DEPTH)+1  rows currently held in the FIFO
- sequence_error  output  1  sticky; an out-of-order index was seen
- overflow  output  1  sticky; a completed row was dropped because the FIFO was full

Behaviour:
- Reset:
  - On a rising clk edge with rst_n=0, clear the assembly buffer, expected index (to 0), FIFO pointers and row_count.
  - row_valid=0, row_data=0, row_count=0, sequence_error=0, overflow=0.
  - Reset mid-row or with rows pending discards all data; no partial row survives.
- Accepting values:
  - Input is sampled on a rising edge only when input_enable=1; other cycles leave assembly state unchanged.
  - The block never backpressures the scaler; there is no input-side ready.
- Assembly state machine: expected index `exp`, range 0..CELL_AMOUNT-1.
  - Enable with `input_index == exp`:
    - store input_value into slot exp;
    - if exp < CELL_AMOUNT-1, exp <= exp+1;
    - if exp == CELL_AMOUNT-1, the row is complete: push it and set exp <= 0.
  - Enable with `input_index == 0` and exp != 0: set sequence_error, discard the partial row, store the value in slot 0, exp <= 1 (resync).
  - Enable with any other mismatched index, or `input_index >= CELL_AMOUNT`: set sequence_error, discard the partial row, exp <= 0, value dropped.
  - With CELL_AMOUNT=1, every in-order value completes a row.
- Row push:
  - The completed row is the stored slots 0..CELL_AMOUNT-2 plus the current input_value for the last slot, written into the FIFO on the same edge.
  - Latency: the last value is sampled at edge N; row_valid/row_data reflect it after edge N, i.e. in cycle N+1, when the FIFO was empty.
- Row FIFO:
  - row_data always shows the head entry; it is 0 when empty.
  - A pop occurs on an edge with row_valid=1 and row_ready=1.
  - row_ready while empty has no effect.
  - Push when not full: accepted.
  - Push when full with no pop that edge: row dropped, overflow set, FIFO unchanged.
  - Push and pop on the same edge when full: both happen; the row is accepted, row_count is unchanged and overflow is not set.
  - Push and pop on the same edge otherwise: both happen, row_count unchanged.
  - Pointers wrap modulo ROW_DEPTH.
- Handshake rule: row_valid, once asserted, stays high and row_data stays stable until the pop edge.
- Sticky flags: sequence_error and overflow clear only on reset.

Test Plan:
- Basic row: reset, then enables with index 0..3 and values 0x11,0x22,0x33,0x44, row_ready=1 → one cycle after the 4th value, row_valid=1 and row_data=0x44332211; popped next edge, row_count returns to 0.
- Back-to-back rows: 12 consecutive enabled values 0x01..0x0C, row_ready=0 → after row 1, row_count=1; after row 2, row_count=2; row 3 dropped and overflow=1. Then raise row_ready → rows 0x04030201 and 0x08070605 pop in order.
- Full with simultaneous pop: FIFO full and row_ready=1 on the same edge the 4th value of a new row arrives → row accepted, row_count stays 2, overflow remains 0.
- Resync: indices 0,1,0,1,2,3 with values A0,A1,B0,B1,B2,B3 → sequence_error=1; only row {B3,B2,B1,B0} is emitted.
- Bad index: indices 0,1,3,… → sequence_error=1, value at index 3 dropped, exp=0. A subsequent 0..3 sequence yields exactly one correct row.
- Reset mid-operation: after indices 0,1 are stored and 1 row is pending, assert rst_n=0 for one edge → row_valid=0, row_count=0, flags 0. A following 0..3 sequence yields a fresh row with no stale slots.

Source files
------------

// File: rtl/result_collector.sv
// result_collector
//   Reassembles the indexed value stream coming out of the scaler into packed
//   rows of CELL_AMOUNT values, buffers completed rows in a small FIFO and
//   hands them downstream over a valid/ready handshake. The block never
//   backpressures the scaler: if a row completes while the FIFO is full and
//   nothing is popped on that edge, the row is dropped and flagged.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   input_index    slot index of the incoming value
//   input_value    scaled value
//   input_enable   index/value valid this cycle
//   row_data       head row of the FIFO, slot i at [i*DATA_WIDTH +: DATA_WIDTH]; 0 when empty
//   row_valid      FIFO non-empty
//   row_ready      downstream accepts row_data this cycle
//   row_count      rows currently held in the FIFO
//   sequence_error sticky: an out-of-order or out-of-range index was seen
//   overflow       sticky: a completed row was dropped because the FIFO was full

module result_collector #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned CELL_AMOUNT = 4,
   parameter int unsigned ROW_DEPTH   = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [DATA_WIDTH-1:0]             input_index,
   input  logic [DATA_WIDTH-1:0]             input_value,
   input  logic                              input_enable,
   output logic [CELL_AMOUNT*DATA_WIDTH-1:0] row_data,
   output logic                              row_valid,
   input  logic                              row_ready,
   output logic [$clog2(ROW_DEPTH):0]        row_count,
   output logic                              sequence_error,
   output logic                              overflow
);

   localparam int unsigned ROW_W = CELL_AMOUNT * DATA_WIDTH;
   localparam int unsigned EXP_W = (CELL_AMOUNT > 1) ? $clog2(CELL_AMOUNT) : 1;
   localparam int unsigned PTR_W = $clog2(ROW_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [EXP_W-1:0] LAST_EXP = EXP_W'(CELL_AMOUNT - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(ROW_DEPTH);

   // Assembly state
   logic [EXP_W-1:0] exp_q, exp_d;
   logic [ROW_W-1:0] slots_q, slots_d;
   logic             seq_err_q, seq_err_d;

   // Row FIFO state
   logic [ROW_W-1:0] mem_q [ROW_DEPTH];
   logic [ROW_W-1:0] mem_d [ROW_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;

   // Internal combinational signals
   logic             in_order;
   logic             is_zero;
   logic             row_done;
   logic [ROW_W-1:0] row_in;
   logic             fifo_empty;
   logic             fifo_full;
   logic             pop;
   logic             push_ok;

   assign in_order = (input_index == DATA_WIDTH'(exp_q));
   assign is_zero  = (input_index == '0);

   // Assembly: in-order values fill slots; index 0 out of turn restarts the
   // row with that value; anything else abandons the row and waits for 0.
   always_comb begin
      exp_d     = exp_q;
      slots_d   = slots_q;
      seq_err_d = seq_err_q;
      row_done  = 1'b0;

      // The completing value bypasses the slot store and goes straight into
      // the pushed row, so the row lands in the FIFO on the same edge.
      row_in = slots_q;
      row_in[(CELL_AMOUNT-1)*DATA_WIDTH +: DATA_WIDTH] = input_value;

      if (input_enable) begin
         if (in_order) begin
            if (exp_q == LAST_EXP) begin
               row_done = 1'b1;
               exp_d    = '0;
               slots_d  = '0;
            end else begin
               slots_d[exp_q*DATA_WIDTH +: DATA_WIDTH] = input_value;
               exp_d = exp_q + EXP_W'(1);
            end
         end else if (is_zero) begin
            seq_err_d = 1'b1;
            slots_d   = '0;
            slots_d[0 +: DATA_WIDTH] = input_value;
            exp_d     = EXP_W'(1);
         end else begin
            seq_err_d = 1'b1;
            slots_d   = '0;
            exp_d     = '0;
         end
      end
   end

   // FIFO: a pop on the same edge frees room for a push even when full.
   always_comb begin
      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == FULL_CNT);
      pop        = !fifo_empty && row_ready;
      push_ok    = row_done && (!fifo_full || pop);
      ovf_d      = ovf_q | (row_done && fifo_full && !pop);

      mem_d = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = row_in;
      end

      wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exp_q     <= '0;
         slots_q   <= '0;
         seq_err_q <= 1'b0;
         mem_q     <= '{default: '0};
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         exp_q     <= exp_d;
         slots_q   <= slots_d;
         seq_err_q <= seq_err_d;
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
      end
   end

   assign row_valid      = (count_q != '0);
   assign row_data       = row_valid ? mem_q[rd_ptr_q] : '0;
   assign row_count      = count_q;
   assign sequence_error = seq_err_q;
   assign overflow       = ovf_q;

endmodule

// File: tb/tb_result_collector.sv
module tb_result_collector;

   localparam int DW = 8;
   localparam int C  = 4;
   localparam int D  = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] input_index = '0;
   logic [DW-1:0] input_value = '0;
   logic          input_enable = 1'b0;
   logic [C*DW-1:0] row_data;
   logic          row_valid;
   logic          row_ready = 1'b0;
   logic [$clog2(D):0] row_count;
   logic          sequence_error;
   logic          overflow;

   result_collector #(
      .DATA_WIDTH (DW),
      .CELL_AMOUNT(C),
      .ROW_DEPTH  (D)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .input_index   (input_index),
      .input_value   (input_value),
      .input_enable  (input_enable),
      .row_data      (row_data),
      .row_valid     (row_valid),
      .row_ready     (row_ready),
      .row_count     (row_count),
      .sequence_error(sequence_error),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: the partial row is a queue whose length is the next
   // expected index; the FIFO is a bounded queue of packed rows.
   logic [DW-1:0]   partial[$];
   logic [C*DW-1:0] mfifo[$];
   logic [C*DW-1:0] sb[$];
   bit              m_seq = 1'b0;
   bit              m_ovf = 1'b0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_apply(bit en, logic [DW-1:0] idx, logic [DW-1:0] val, bit rdy);
      bit done = 1'b0;
      logic [C*DW-1:0] row = '0;
      bit pop;
      pop = (mfifo.size() > 0) && rdy;
      if (en) begin
         if (int'(idx) == partial.size()) begin
            partial.push_back(val);
            if (partial.size() == C) begin
               for (int i = 0; i < C; i++) row[i*DW +: DW] = partial[i];
               done = 1'b1;
               partial.delete();
            end
         end else begin
            m_seq = 1'b1;
            partial.delete();
            if (idx == 0) partial.push_back(val);
         end
      end
      if (pop) void'(mfifo.pop_front());
      if (done) begin
         if (mfifo.size() < D) begin
            mfifo.push_back(row);
            sb.push_back(row);
         end else begin
            m_ovf = 1'b1;
         end
      end
   endtask

   // Called at posedge+1: checks the state after the previous edge, then
   // drives the inputs for the next edge.
   task automatic step(bit en, logic [DW-1:0] idx, logic [DW-1:0] val, bit rdy);
      check("row_count", row_count, mfifo.size());
      check("row_valid", row_valid, mfifo.size() > 0);
      check("sequence_error", sequence_error, m_seq);
      check("overflow", overflow, m_ovf);
      if (mfifo.size() == 0) check("row_data_empty", row_data, 0);
      input_enable = en;
      input_index  = idx;
      input_value  = val;
      row_ready    = rdy;
      model_apply(en, idx, val, rdy);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      input_enable = 1'b0;
      row_ready    = 1'b0;
      rst_n        = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      partial.delete();
      mfifo.delete();
      sb.delete();
      m_seq = 1'b0;
      m_ovf = 1'b0;
   endtask

   task automatic drain(int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1);
   endtask

   // Monitor: pops the scoreboard whenever a handshake is about to complete
   // and checks that a stalled row holds steady.
   logic [C*DW-1:0] prev_data = '0;
   bit              prev_hold = 1'b0;
   always @(negedge clk) begin
      if (prev_hold) begin
         check("hold_valid", row_valid, 1);
         check("hold_data", row_data, prev_data);
      end
      prev_hold = rst_n && row_valid && !row_ready;
      prev_data = row_data;
      if (rst_n && row_valid && row_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL pop_unexpected: got %h expected no row", row_data);
         end else begin
            check("row_data", row_data, sb.pop_front());
         end
      end
   end

   initial begin
      logic [DW-1:0] ridx;
      int r;

      // Basic row
      do_reset();
      step(1'b1, 8'd0, 8'h11, 1'b1);
      step(1'b1, 8'd1, 8'h22, 1'b1);
      step(1'b1, 8'd2, 8'h33, 1'b1);
      step(1'b1, 8'd3, 8'h44, 1'b1);
      check("basic_row_value", row_data, 32'h44332211);
      drain(2);

      // Back-to-back rows into a stalled FIFO, third row dropped
      do_reset();
      for (int v = 1; v <= 12; v++) step(1'b1, 8'((v-1) % C), 8'(v), 1'b0);
      check("b2b_head", row_data, 32'h04030201);
      check("b2b_overflow", overflow, 1);
      drain(4);

      // Full FIFO with a pop on the edge the next row completes
      do_reset();
      for (int v = 1; v <= 11; v++) step(1'b1, 8'((v-1) % C), 8'(v), 1'b0);
      step(1'b1, 8'd3, 8'd12, 1'b1);
      check("fullpop_count", row_count, 2);
      check("fullpop_overflow", overflow, 0);
      drain(4);

      // Resync on an early index 0
      do_reset();
      step(1'b1, 8'd0, 8'hA0, 1'b1);
      step(1'b1, 8'd1, 8'hA1, 1'b1);
      step(1'b1, 8'd0, 8'hB0, 1'b1);
      step(1'b1, 8'd1, 8'hB1, 1'b1);
      step(1'b1, 8'd2, 8'hB2, 1'b1);
      step(1'b1, 8'd3, 8'hB3, 1'b1);
      check("resync_row", row_data, 32'hB3B2B1B0);
      drain(3);

      // Bad index, then out-of-range index, then a clean row
      do_reset();
      step(1'b1, 8'd0, 8'h10, 1'b1);
      step(1'b1, 8'd1, 8'h20, 1'b1);
      step(1'b1, 8'd3, 8'h30, 1'b1);
      step(1'b1, 8'd7, 8'h40, 1'b1);
      for (int v = 0; v < C; v++) step(1'b1, 8'(v), 8'(8'h50 + v), 1'b1);
      drain(3);

      // Reset with a row pending and a partial row stored
      do_reset();
      for (int v = 0; v < C; v++) step(1'b1, 8'(v), 8'(8'hC0 + v), 1'b0);
      step(1'b1, 8'd0, 8'hD0, 1'b0);
      step(1'b1, 8'd1, 8'hD1, 1'b0);
      do_reset();
      step(1'b1, 8'd0, 8'hE0, 1'b1);
      step(1'b1, 8'd1, 8'hE1, 1'b1);
      step(1'b1, 8'd2, 8'hE2, 1'b1);
      step(1'b1, 8'd3, 8'hE3, 1'b1);
      check("post_reset_row", row_data, 32'hE3E2E1E0);
      drain(3);

      // Randomized traffic, mostly in-order with occasional faults and resets
      do_reset();
      for (int n = 0; n < 600; n++) begin
         r = int'($urandom_range(0, 19));
         if (r < 15)      ridx = 8'(partial.size());
         else if (r < 17) ridx = '0;
         else             ridx = 8'($urandom_range(0, 5));
         if ($urandom_range(0, 249) == 0) do_reset();
         else step($urandom_range(0, 9) < 8, ridx, 8'($urandom), 1'($urandom_range(0, 1)));
      end
      drain(6);
      check("scoreboard_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
